// File: rtl/i2c_req_arbiter.sv
// Two-requester arbiter in front of a single I2C write controller (IDLE/ISSUE/WAIT/GAP).
// Define I2C_ARB_RETRY_EN to retry NACKed transfers up to MAX_RETRY times.
module i2c_req_arbiter #(
  parameter logic [1:0]  MAX_RETRY   = 2'd3,
  parameter logic [15:0] TIMEOUT_CYC = 16'd65535,
  parameter logic [3:0]  GAP_CYC     = 4'd2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_data,
  output logic        req1_ready,
  output logic        rsp0_done,
  output logic        rsp1_done,
  output logic [1:0]  rsp_err,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  input  logic        i2c_end,
  input  logic        i2c_ack,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_e;

  localparam logic [3:0] GapLen = (GAP_CYC == 4'd0) ? 4'd1 : GAP_CYC;
  localparam logic [1:0] ErrOk  = 2'b00;
  localparam logic [1:0] ErrNak = 2'b01;
  localparam logic [1:0] ErrTmo = 2'b10;

  state_e      state_q, state_d;
  logic [23:0] data_q, data_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        end_prev_q;
  logic        go_q, go_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [1:0]  err_q, err_d;

  logic        grant;
  logic        accept;
  logic        end_rise;
  logic        tmo_hit;
  logic        gap_last;
  logic        fin;
  logic [1:0]  fin_err;
  logic        retry_pend;

`ifdef I2C_ARB_RETRY_EN
  logic [1:0] retry_cnt_q, retry_cnt_d;
  logic       retry_pend_q, retry_pend_d;
  assign retry_pend = retry_pend_q;
`else
  assign retry_pend = 1'b0;
`endif

  // On a tie the requester that did not win last time is served.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state_q == IDLE) && !grant && !reset;
  assign req1_ready = (state_q == IDLE) &&  grant && !reset;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign end_rise = i2c_end && !end_prev_q;
  assign tmo_hit  = ({1'b0, tmo_cnt_q} + 17'd1) == {1'b0, TIMEOUT_CYC};
  assign gap_last = (gap_cnt_q == GapLen - 4'd1);

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = ErrOk;
    fin          = 1'b0;
    fin_err      = ErrOk;
`ifdef I2C_ARB_RETRY_EN
    retry_cnt_d  = retry_cnt_q;
    retry_pend_d = retry_pend_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d       = grant ? req1_data : req0_data;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = ISSUE;
`ifdef I2C_ARB_RETRY_EN
          retry_cnt_d  = '0;
          retry_pend_d = 1'b0;
`endif
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        // Timeout is checked first so it wins over a same-cycle completion.
        if (tmo_hit) begin
          fin     = 1'b1;
          fin_err = ErrTmo;
        end else if (end_rise) begin
          if (!i2c_ack) begin
            fin     = 1'b1;
            fin_err = ErrOk;
          end else begin
`ifdef I2C_ARB_RETRY_EN
            if (retry_cnt_q < MAX_RETRY) begin
              retry_cnt_d  = retry_cnt_q + 2'd1;
              retry_pend_d = 1'b1;
              gap_cnt_d    = '0;
              state_d      = GAP;
            end else begin
              fin     = 1'b1;
              fin_err = ErrNak;
            end
`else
            fin     = 1'b1;
            fin_err = ErrNak;
`endif
          end
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = retry_pend ? ISSUE : IDLE;
`ifdef I2C_ARB_RETRY_EN
          retry_pend_d = 1'b0;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d   = GAP;
      gap_cnt_d = '0;
      done0_d   = ~owner_q;
      done1_d   = owner_q;
      err_d     = fin_err;
    end

    go_d = (state_d == ISSUE) || (state_d == WAIT);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      data_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      end_prev_q   <= 1'b0;
      go_q         <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= ErrOk;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      end_prev_q   <= i2c_end;
      go_q         <= go_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
    end
  end

`ifdef I2C_ARB_RETRY_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      retry_cnt_q  <= '0;
      retry_pend_q <= 1'b0;
    end else begin
      retry_cnt_q  <= retry_cnt_d;
      retry_pend_q <= retry_pend_d;
    end
  end
`endif

  assign i2c_data  = data_q;
  assign i2c_go    = go_q;
  assign rsp0_done = done0_q;
  assign rsp1_done = done1_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: a controller model answers each go, a monitor checks responses.
module tb_i2c_req_arbiter;
  localparam int TMO  = 100;
  localparam int GAP  = 2;
  localparam int MAXR = 3;
`ifdef I2C_ARB_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        CLOCK_50;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rsp0_done, rsp1_done;
  logic [1:0]  rsp_err;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic        i2c_ack;
  logic        busy;

  i2c_req_arbiter #(
    .MAX_RETRY  (2'(MAXR)),
    .TIMEOUT_CYC(16'(TMO)),
    .GAP_CYC    (4'(GAP))
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .rsp0_done (rsp0_done),
    .rsp1_done (rsp1_done),
    .rsp_err   (rsp_err),
    .i2c_data  (i2c_data),
    .i2c_go    (i2c_go),
    .i2c_end   (i2c_end),
    .i2c_ack   (i2c_ack),
    .busy      (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // kind: 0 ack, 1 nack, 2 no end (timeout), 3 hang until reset
  typedef struct { int kind; int d; int pre; int gapchk; } att_t;
  typedef struct { int owner; logic [23:0] data; int err; } rsp_t;

  att_t att_q[$];
  rsp_t exp_q[$];
  rsp_t acc_q[$];

  int          checks = 0;
  int          errors = 0;
  int          busy_cd = 0;
  bit          end_hold = 1'b0;
  int          m_last = 1;
  int          p_kind[2][4];
  int          p_d[2][4];
  int          p_pre[2];
  logic [23:0] p_data[2];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_ge(input string name, input longint act, input longint lim);
    checks++;
    if (act < lim) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d (cycle %0d)", name, act, lim, cyc);
    end
  endtask

  task automatic fixed_plan(input int n, input int kind, input int d);
    for (int i = 0; i < 4; i++) begin
      p_kind[n][i] = kind;
      p_d[n][i]    = d;
    end
    p_pre[n] = 0;
  endtask

  task automatic rand_plan(input int n);
    int r;
    for (int i = 0; i < 4; i++) begin
      r = int'($urandom_range(0, 99));
      p_kind[n][i] = (r < 50) ? 0 : (r < 85) ? 1 : 2;
      p_d[n][i]    = int'($urandom_range(2, 12));
    end
    p_pre[n]  = 0;
    p_data[n] = 24'($urandom);
  endtask

  // Reference model: walk the attempt list by the arbiter's rules to get the final response.
  task automatic commit_txn(input int n, input bit nogap);
    att_t a;
    rsp_t r;
    int   err;
    err = -1;
    for (int i = 0; i < 4 && err < 0; i++) begin
      a.kind   = p_kind[n][i];
      a.d      = p_d[n][i];
      a.pre    = (i == 0) ? p_pre[n] : 0;
      a.gapchk = (i > 0) ? 1 : (nogap ? 0 : 2);
      att_q.push_back(a);
      if (a.kind == 2 || a.d - 1 >= TMO) err = 2;
      else if (a.kind == 0)              err = 0;
      else if (!(RETRY && i < MAXR))     err = 1;
    end
    r.owner = n;
    r.data  = p_data[n];
    r.err   = err;
    exp_q.push_back(r);
    acc_q.push_back(r);
    m_last = n;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || att_q.size() != 0 || acc_q.size() != 0 || busy || busy_cd != 0)
           && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL idle_wait: exp=%0d att=%0d acc=%0d busy=%b", exp_q.size(), att_q.size(),
               acc_q.size(), busy);
      exp_q.delete();
      att_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic drive_round(input bit v0, input bit v1);
    bit a0, a1, pend0, pend1;
    int budget;
    pend0 = v0;
    pend1 = v1;
    @(posedge CLOCK_50);
    #1;
    req0_data  = v0 ? p_data[0] : 24'($urandom);
    req1_data  = v1 ? p_data[1] : 24'($urandom);
    req0_valid = v0;
    req1_valid = v1;
    budget = 0;
    while ((pend0 || pend1) && budget < 3000) begin
      @(negedge CLOCK_50);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge CLOCK_50);
      #1;
      if (a0) begin req0_valid = 1'b0; req0_data = 24'($urandom); pend0 = 1'b0; end_hold = 1'b0; end
      if (a1) begin req1_valid = 1'b0; req1_data = 24'($urandom); pend1 = 1'b0; end_hold = 1'b0; end
      budget++;
    end
    checks++;
    if (pend0 || pend1) begin
      errors++;
      $display("FAIL accept_wait: pending0=%b pending1=%b", pend0, pend1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    wait_idle();
  endtask

  task automatic tie_round();
    int first;
    p_data[0] = 24'($urandom);
    p_data[1] = 24'($urandom);
    fixed_plan(0, 0, 3);
    fixed_plan(1, 0, 3);
    first = (m_last == 1) ? 0 : 1;
    commit_txn(first, 1'b0);
    commit_txn(1 - first, 1'b0);
    drive_round(1'b1, 1'b1);
  endtask

  // Controller model: answers each go assertion with the next scripted attempt.
  initial begin
    att_t a;
    int   c, low, exp_dur;
    i2c_end = 1'b0;
    i2c_ack = 1'b0;
    low = 1000;
    forever begin
      @(negedge CLOCK_50);
      if (!i2c_go) begin
        low++;
        i2c_end = end_hold;
      end else begin
        checks++;
        if (att_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_go: no attempt scripted (cycle %0d)", cyc);
          a = '{kind: 3, d: 0, pre: 0, gapchk: 0};
        end else begin
          a = att_q.pop_front();
        end
        if (a.gapchk == 1)      chk("retry_gap", low, GAP);
        else if (a.gapchk == 2) chk_ge("txn_gap", low, GAP + 1);
        c = 0;
        while (i2c_go && c < 400) begin
          c++;
          if (a.kind < 2 && c >= a.d) begin
            i2c_end = 1'b1;
            i2c_ack = (a.kind == 1);
          end else if (c > a.pre) begin
            i2c_end = 1'b0;
          end
          @(negedge CLOCK_50);
        end
        if (a.kind == 2)     exp_dur = 1 + TMO;
        else                 exp_dur = (a.d < 1 + TMO) ? a.d : 1 + TMO;
        if (a.kind != 3) chk("go_len", c, exp_dur);
        i2c_end = 1'b0;
        i2c_ack = 1'b0;
        low = 1;
      end
    end
  end

  // Monitor: acceptance order, latched data, responses and busy after the gap.
  initial begin
    rsp_t r, pa;
    bit   pa_v;
    int   owner, last_acc;
    pa_v = 1'b0;
    last_acc = -100;
    forever begin
      @(negedge CLOCK_50);
      if (pa_v) begin
        chk("latched_data", i2c_data, pa.data);
        pa_v = 1'b0;
      end
      if (!reset && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
        owner = (req1_valid && req1_ready) ? 1 : 0;
        chk("one_ready", req0_ready & req1_ready, 0);
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_accept: owner %0d (cycle %0d)", owner, cyc);
        end else begin
          pa = acc_q.pop_front();
          chk("accept_owner", owner, pa.owner);
          pa_v = 1'b1;
        end
        chk_ge("accept_spacing", cyc - last_acc, 5);
        last_acc = cyc;
      end
      if (busy_cd == 2) begin
        chk("busy_in_gap", busy, 1);
        busy_cd = 1;
      end else if (busy_cd == 1) begin
        chk("busy_after_gap", busy, 0);
        busy_cd = 0;
      end
      if (rsp0_done || rsp1_done) begin
        chk("done_onehot", rsp0_done & rsp1_done, 0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done0=%b done1=%b (cycle %0d)", rsp0_done, rsp1_done, cyc);
        end else begin
          r = exp_q.pop_front();
          chk("rsp_owner", rsp1_done ? 1 : 0, r.owner);
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_data", i2c_data, r.data);
        end
        busy_cd = 2;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   a1, pend1;
    int   mask, n;
    att_t ha;
    rsp_t hr;

    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 24'hABCDEF;
    req1_data  = 24'h123456;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_go", i2c_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done0", rsp0_done, 0);
    chk("rst_done1", rsp1_done, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset      = 1'b0;
    @(posedge CLOCK_50);
    #1;

    // Ties straight after reset: req0 first, then alternation.
    tie_round();
    tie_round();

    p_data[0] = 24'h340E05;
    fixed_plan(0, 0, 11);
    commit_txn(0, 1'b0);
    drive_round(1'b1, 1'b0);

    p_data[1] = 24'h5A5A5A;
    fixed_plan(1, 1, 4);
    commit_txn(1, 1'b0);
    drive_round(1'b0, 1'b1);

    p_data[0] = 24'hC0FFEE;
    fixed_plan(0, 2, 0);
    commit_txn(0, 1'b0);
    drive_round(1'b1, 1'b0);

    // Completion on the same cycle as the timeout, then one cycle earlier.
    p_data[1] = 24'h0F0F0F;
    fixed_plan(1, 0, TMO + 1);
    commit_txn(1, 1'b0);
    drive_round(1'b0, 1'b1);
    p_data[0] = 24'h00FF00;
    fixed_plan(0, 0, TMO);
    commit_txn(0, 1'b0);
    drive_round(1'b1, 1'b0);

    // i2c_end already high when WAIT begins.
    p_data[0] = 24'h777777;
    fixed_plan(0, 0, 7);
    p_pre[0] = 3;
    commit_txn(0, 1'b0);
    p_pre[0] = 0;
    end_hold = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    drive_round(1'b1, 1'b0);

    // Reset while WAITing: no response, req1 taken in the first IDLE cycle after.
    p_data[0] = 24'($urandom);
    ha = '{kind: 3, d: 0, pre: 0, gapchk: 2};
    att_q.push_back(ha);
    hr = '{owner: 0, data: p_data[0], err: 0};
    acc_q.push_back(hr);
    m_last = 0;
    @(posedge CLOCK_50);
    #1;
    req0_data  = p_data[0];
    req0_valid = 1'b1;
    n = 0;
    while (req0_valid && n < 100) begin
      @(negedge CLOCK_50);
      a1 = req0_ready;
      @(posedge CLOCK_50);
      #1;
      if (a1) req0_valid = 1'b0;
      n++;
    end
    repeat (6) @(posedge CLOCK_50);
    #1;
    chk("hang_go", i2c_go, 1);
    p_data[1] = 24'($urandom);
    fixed_plan(1, 0, 5);
    commit_txn(1, 1'b1);
    req1_data  = p_data[1];
    req1_valid = 1'b1;
    chk("ready_not_idle", req1_ready, 0);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    chk("reset_go", i2c_go, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready1", req1_ready, 0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    #1;
    chk("ready_after_reset", req1_ready, 1);
    pend1 = 1'b1;
    n = 0;
    while (pend1 && n < 100) begin
      @(negedge CLOCK_50);
      a1 = req1_valid && req1_ready;
      @(posedge CLOCK_50);
      #1;
      if (a1) begin req1_valid = 1'b0; pend1 = 1'b0; end
      n++;
    end
    wait_idle();

    for (int k = 0; k < 30; k++) begin
      mask = int'($urandom_range(1, 3));
      if (mask == 3) begin
        rand_plan(0);
        rand_plan(1);
        if (m_last == 1) begin commit_txn(0, 1'b0); commit_txn(1, 1'b0); end
        else             begin commit_txn(1, 1'b0); commit_txn(0, 1'b0); end
        drive_round(1'b1, 1'b1);
      end else begin
        n = mask - 1;
        rand_plan(n);
        if ($urandom_range(0, 3) == 0) begin
          p_pre[n]    = int'($urandom_range(1, 3));
          p_d[n][0]   = p_pre[n] + 2 + int'($urandom_range(0, 6));
          end_hold    = 1'b1;
        end
        commit_txn(n, 1'b0);
        p_pre[n] = 0;
        repeat (int'($urandom_range(1, 3))) @(posedge CLOCK_50);
        drive_round(n == 0, n == 1);
      end
    end

    repeat (5) @(posedge CLOCK_50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, giving the NACK retries per transaction (2-bit range, 0..3).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, giving the CLOCK_50 cycles allowed in WAIT before abort (16-bit).
REQ-003 SHALL have parameter GAP_CYC, default 2, giving the idle cycles with i2c_go low after each transaction (4-bit, minimum 1).
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the sole clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports req0_valid/req1_valid, input, 1 bit each: the requester holds a transaction.
REQ-007 SHALL have ports req0_data/req1_data, input, 24 bits each: {slave_addr, sub_addr, data}.
REQ-008 SHALL have ports req0_ready/req1_ready, output, 1 bit each: accept strobe.
REQ-009 SHALL have ports rsp0_done/rsp1_done, output, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL have port rsp_err, output, 2 bits: 00 ok, 01 NACK, 10 timeout; valid only with a rspN_done pulse.
REQ-011 SHALL have port i2c_data, output, 24 bits: to the I2C controller.
REQ-012 SHALL have port i2c_go, output, 1 bit: level, held until completion.
REQ-013 SHALL have port i2c_end, input, 1 bit: controller end flag.
REQ-014 SHALL have port i2c_ack, input, 1 bit: 1 = slave did not acknowledge.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT and GAP.
REQ-017 SHALL, in IDLE, grant combinationally: a single valid requester wins; if both are valid, the requester not in last_grant wins.
REQ-018 SHALL drive reqN_ready = (state==IDLE) & grant==N; acceptance is reqN_valid & reqN_ready.
REQ-019 SHALL, on acceptance, latch reqN_data into i2c_data, record the owner, set last_grant=N, clear retry_cnt and move to ISSUE.
REQ-020 SHALL, in ISSUE, assert i2c_go, clear the timeout counter and move to WAIT on the next edge.
REQ-021 SHALL, in WAIT, hold i2c_go high and treat completion as a rising edge of i2c_end (previous 0, current 1).
REQ-022 SHALL treat a level-high i2c_end without a rising edge in WAIT as not complete.
REQ-023 SHALL, on completion with i2c_ack=0, drop i2c_go, pulse rsp<owner>_done with rsp_err=00 and enter GAP.
REQ-024 SHALL, when the timeout counter reaches TIMEOUT_CYC before completion, drop i2c_go, pulse done with rsp_err=10 and enter GAP.
REQ-025 SHALL give timeout priority when completion and timeout occur in the same cycle.
REQ-026 SHALL, in GAP, keep i2c_go low for GAP_CYC cycles, then go to ISSUE if a retry is pending, otherwise to IDLE.
REQ-027 SHALL keep i2c_data stable from acceptance until the final GAP exit.
REQ-028 SHALL pulse exactly one rspN_done per accepted transaction, to the owner only.
REQ-029 SHALL allow the earliest next acceptance in the first IDLE cycle after GAP, so requests are never accepted back-to-back.
REQ-030 SHALL ignore reqN_valid outside IDLE; the requester holds valid and data until ready.

Reset
REQ-031 SHALL, on a reset-sampled edge, set state=IDLE, i2c_go=0, i2c_data=0, rspN_done=0, rsp_err=00, retry_cnt=0, counters=0 and last_grant=1, so req0 wins the first tie.
REQ-032 SHALL abort an in-flight transaction on reset mid-operation with no rspN_done pulse.
REQ-033 SHALL hold reqN_ready low while reset is high.

Configuration
REQ-034 SHALL provide retry behaviour under macro I2C_ARB_RETRY_EN.
REQ-035 SHALL, with I2C_ARB_RETRY_EN defined, on NACK completion with retry_cnt<MAX_RETRY: increment retry_cnt, drop i2c_go, emit no rsp, and go to GAP then ISSUE; with retry_cnt==MAX_RETRY, pulse done with rsp_err=01.
REQ-036 SHALL, with I2C_ARB_RETRY_EN undefined, on NACK pulse done with rsp_err=01 and go to GAP; no retry_cnt logic is present.
REQ-037 SHALL never retry a timeout in either build.

Verification
REQ-038 SHALL cover: req0 alone with data 0x34_0E_05, ack=0 after 10 cycles -> i2c_data=0x340E05, go high 11 cycles, rsp0_done pulse, rsp_err=00.
REQ-039 SHALL cover: req0 and req1 valid together after reset -> req0 granted first, req1 second; repeating the tie -> req0 then req1 alternate, no back-to-back acceptance.
REQ-040 SHALL cover: RETRY_EN build, MAX_RETRY=3, ack=1 always -> 4 go assertions, each separated by 2 low cycles, one rsp_done with rsp_err=01.
REQ-041 SHALL cover: TIMEOUT_CYC=100, i2c_end held 0 -> go drops after 100 WAIT cycles, rsp_err=10, busy low after GAP.
REQ-042 SHALL cover: reset asserted in WAIT -> go=0 next edge, no rsp pulse, new req1 accepted in the first IDLE cycle after reset.
REQ-043 SHALL cover: i2c_end already high when entering WAIT, then falls and rises -> completion only on the rise.
